// File: rtl/jtpang_objdma.sv
// Object DMA controller: on a dma_go rising edge, requests the Z80 bus and
// copies OBJ_BYTES bytes from CPU work RAM into the video object buffer.
module jtpang_objdma #(
    parameter int unsigned OBJ_BYTES = 512,
    parameter logic [11:0] SRC_BASE  = 12'h000,
    parameter int unsigned ACK_TO    = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic        dma_go,
    input  logic        busak_n,
    output logic        busrq,
    output logic [11:0] ram_addr,
    input  logic [7:0]  ram_dout,
    output logic [8:0]  obj_addr,
    output logic [7:0]  obj_din,
    output logic        obj_we,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned   CW      = $clog2(OBJ_BYTES) + 1;
    localparam int unsigned   TW      = 10;
    localparam logic [CW-1:0] LAST    = CW'(OBJ_BYTES - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(ACK_TO - 1);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, XFER, RELEASE} state_t;

    state_t        state, state_nx;
    logic          go_prev, rise;
    logic          pending, pending_nx;
    logic [CW-1:0] rd_cnt, rd_cnt_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          busrq_nx, busy_nx, err_nx, we_nx, done_nx;
    logic [11:0]   ram_addr_nx;
    logic [8:0]    obj_addr_nx;
    logic [7:0]    obj_din_nx;

    assign rise = dma_go & ~go_prev;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (cen) begin
            state <= state_nx;
        end
    end

    // Next state and next register values, evaluated for a cen tick
    always_comb begin
        state_nx    = state;
        pending_nx  = pending;
        rd_cnt_nx   = rd_cnt;
        timer_nx    = timer;
        busrq_nx    = busrq;
        busy_nx     = busy;
        err_nx      = err;
        we_nx       = 1'b0;
        done_nx     = 1'b0;
        ram_addr_nx = ram_addr;
        obj_addr_nx = obj_addr;
        obj_din_nx  = obj_din;
        if (rise && state != IDLE) pending_nx = 1'b1;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_nx = WAIT_ACK;
                    busrq_nx = 1'b1;
                    busy_nx  = 1'b1;
                    err_nx   = 1'b0;
                    timer_nx = '0;
                end
            end
            WAIT_ACK: begin
                if (!busak_n) begin
                    state_nx    = XFER;
                    rd_cnt_nx   = '0;
                    ram_addr_nx = SRC_BASE;
                end else if (timer == TO_LAST) begin
                    state_nx   = IDLE;
                    busrq_nx   = 1'b0;
                    busy_nx    = 1'b0;
                    err_nx     = 1'b1;
                    pending_nx = 1'b0;
                end else begin
                    timer_nx = timer + TW'(1);
                end
            end
            XFER: begin
                // Bus lost: hold the counter so the pending address is re-read
                if (!busak_n) begin
                    we_nx       = 1'b1;
                    obj_addr_nx = 9'(rd_cnt);
                    obj_din_nx  = ram_dout;
                    rd_cnt_nx   = rd_cnt + CW'(1);
                    ram_addr_nx = SRC_BASE + 12'(rd_cnt_nx);
                    if (rd_cnt == LAST) state_nx = RELEASE;
                end
            end
            RELEASE: begin
                done_nx = 1'b1;
                if (pending || rise) begin
                    state_nx   = WAIT_ACK;
                    pending_nx = 1'b0;
                    timer_nx   = '0;
                    err_nx     = 1'b0;
                end else begin
                    state_nx = IDLE;
                    busrq_nx = 1'b0;
                    busy_nx  = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            go_prev  <= 1'b0;
            pending  <= 1'b0;
            rd_cnt   <= '0;
            timer    <= '0;
            busrq    <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            obj_we   <= 1'b0;
            obj_addr <= '0;
            obj_din  <= '0;
            ram_addr <= SRC_BASE;
        end else if (cen) begin
            go_prev  <= dma_go;
            pending  <= pending_nx;
            rd_cnt   <= rd_cnt_nx;
            timer    <= timer_nx;
            busrq    <= busrq_nx;
            busy     <= busy_nx;
            err      <= err_nx;
            obj_we   <= we_nx;
            obj_addr <= obj_addr_nx;
            obj_din  <= obj_din_nx;
            ram_addr <= ram_addr_nx;
        end
    end

    // done lasts a single clk even when cen ticks are sparse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else begin
            done <= cen && done_nx;
        end
    end

endmodule

// File: tb/tb_jtpang_objdma.sv
// Scoreboard bench for jtpang_objdma: a small 4-byte instance and a full 512-byte one.
module tb_jtpang_objdma;

    typedef struct packed {logic id; logic [8:0] a; logic [7:0] d;} wr_t;
    typedef struct packed {logic id; logic dn; logic er;} ev_t;

    logic        clk, rst_n, cen;
    logic        go_v     [2];
    logic        bak_v    [2];
    logic        busrq_v  [2];
    logic [11:0] ram_addr_v [2];
    logic [7:0]  ram_dout_v [2];
    logic [8:0]  obj_addr_v [2];
    logic [7:0]  obj_din_v  [2];
    logic        we_v     [2];
    logic        busy_v   [2];
    logic        done_v   [2];
    logic        err_v    [2];
    logic        err_q    [2];
    logic [7:0]  mem_a [4096];
    logic [7:0]  mem_b [4096];

    wr_t wq[$];
    ev_t eq[$];
    int  total = 0;
    int  bad   = 0;

    assign ram_dout_v[0] = mem_a[ram_addr_v[0]];
    assign ram_dout_v[1] = mem_b[ram_addr_v[1]];

    jtpang_objdma #(.OBJ_BYTES(4), .SRC_BASE(12'hFFE), .ACK_TO(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .cen(cen), .dma_go(go_v[0]), .busak_n(bak_v[0]),
        .busrq(busrq_v[0]), .ram_addr(ram_addr_v[0]), .ram_dout(ram_dout_v[0]),
        .obj_addr(obj_addr_v[0]), .obj_din(obj_din_v[0]), .obj_we(we_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0])
    );

    jtpang_objdma #(.OBJ_BYTES(512), .SRC_BASE(12'hE00), .ACK_TO(255)) dut_b (
        .clk(clk), .rst_n(rst_n), .cen(cen), .dma_go(go_v[1]), .busak_n(bak_v[1]),
        .busrq(busrq_v[1]), .ram_addr(ram_addr_v[1]), .ram_dout(ram_dout_v[1]),
        .obj_addr(obj_addr_v[1]), .obj_din(obj_din_v[1]), .obj_we(we_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cen ticks on every other clk; it changes just after posedge
    initial begin
        cen = 1'b0;
        forever begin
            @(posedge clk);
            #1 cen = ~cen;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Advance to the negedge just before the next cen tick
    task automatic tk;
        do @(negedge clk); while (!cen);
    endtask

    task automatic push_w(input int id, input int n);
        wr_t w;
        for (int k = 0; k < n; k++) begin
            w.id = 1'(id);
            w.a  = 9'(k);
            if (id == 0) w.d = 8'hA0 + 8'(k);
            else         w.d = 8'(k) + 8'(14 + k / 256);
            wq.push_back(w);
        end
    endtask

    task automatic push_e(input int id, input bit dn);
        ev_t e;
        e.id = 1'(id);
        e.dn = dn;
        e.er = ~dn;
        eq.push_back(e);
    endtask

    // Scoreboard monitor: consumes writes and done/err events as the DUTs show them
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (cen && we_v[i]) begin
                if (wq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL write%0d: unexpected addr=%0h data=%0h", i, obj_addr_v[i], obj_din_v[i]);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk($sformatf("write%0d", i), 32'({1'(i), obj_addr_v[i], obj_din_v[i]}), 32'(w));
                end
            end
            if (done_v[i] || (err_v[i] && !err_q[i])) begin
                if (eq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL event%0d: unexpected done=%0b err=%0b", i, done_v[i], err_v[i]);
                end else begin
                    ev_t e;
                    e = eq.pop_front();
                    chk($sformatf("event%0d", i), 32'({1'(i), done_v[i], err_v[i]}), 32'(e));
                end
            end
            err_q[i] = err_v[i];
        end
    end

    // One triggered run; counts cen periods with busrq high
    task automatic run(input int i, input int gd, input int ls, input int ll,
                       input bit retrig, input int exp_hi, input string nm);
        int hi;
        hi = 0;
        tk;
        go_v[i] = 1'b1;
        for (int t = 1; t < 2000; t++) begin
            tk;
            if (t == 1) begin
                chk({nm, " busy"}, 32'(busy_v[i]), 1);
                chk({nm, " err clear"}, 32'(err_v[i]), 0);
            end
            if (!busrq_v[i]) break;
            hi++;
            if (ll > 0 && (t - 1) >= gd + ls && (t - 1) < gd + ls + ll)
                chk({nm, " we in gap"}, 32'(we_v[i]), 0);
            bak_v[i] = !(t >= gd && !(t >= gd + ls && t < gd + ls + ll));
            if (retrig) begin
                if (t == gd + 1 || t == gd + 3) go_v[i] = 1'b0;
                if (t == gd + 2 || t == gd + 4) go_v[i] = 1'b1;
            end
        end
        chk({nm, " busrq ticks"}, hi, exp_hi);
        go_v[i]  = 1'b0;
        bak_v[i] = 1'b1;
        tk;
        tk;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem_a[i] = 8'hA2 + 8'(i);
            mem_b[i] = 8'(i) + 8'(i >> 8);
        end
        for (int i = 0; i < 2; i++) begin
            go_v[i]  = 1'b0;
            bak_v[i] = 1'b1;
            err_q[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst busrq", 32'(busrq_v[0]), 0);
        chk("rst busy", 32'(busy_v[0]), 0);
        chk("rst done", 32'(done_v[0]), 0);
        chk("rst err", 32'(err_v[0]), 0);
        chk("rst obj_we", 32'(we_v[0]), 0);
        chk("rst obj_addr", 32'(obj_addr_v[0]), 0);
        chk("rst obj_din", 32'(obj_din_v[0]), 0);
        chk("rst ram_addr a", 32'(ram_addr_v[0]), 32'h0FFE);
        chk("rst ram_addr b", 32'(ram_addr_v[1]), 32'h0E00);
        rst_n = 1'b1;
        tk; tk;

        // Basic: grant 3 ticks after busrq; source crosses 12'hFFF
        push_w(0, 4); push_e(0, 1'b1);
        run(0, 3, 0, 0, 1'b0, 8, "basic");

        // Bus lost for 3 ticks at byte 2
        push_w(0, 4); push_e(0, 1'b1);
        run(0, 3, 3, 3, 1'b0, 11, "busloss");

        // Two rises during XFER merge into one extra run
        push_w(0, 4); push_e(0, 1'b1);
        push_w(0, 4); push_e(0, 1'b1);
        run(0, 3, 0, 0, 1'b1, 14, "retrig");

        // Acknowledge timeout, then a new trigger clears err
        push_e(0, 1'b0);
        run(0, 9999, 0, 0, 1'b0, 8, "timeout");
        chk("timeout err", 32'(err_v[0]), 1);
        chk("timeout busy", 32'(busy_v[0]), 0);
        push_w(0, 4); push_e(0, 1'b1);
        run(0, 2, 0, 0, 1'b0, 7, "after_to");
        chk("after_to err", 32'(err_v[0]), 0);

        // Full 512-byte copy
        push_w(1, 512); push_e(1, 1'b1);
        run(1, 2, 0, 0, 1'b0, 515, "full");

        // Reset during XFER after the first byte
        push_w(0, 1);
        tk;
        go_v[0] = 1'b1;
        tk; tk;
        bak_v[0] = 1'b0;
        tk; tk;
        #2 rst_n = 1'b0;
        #1;
        chk("rst mid busrq", 32'(busrq_v[0]), 0);
        chk("rst mid obj_we", 32'(we_v[0]), 0);
        chk("rst mid busy", 32'(busy_v[0]), 0);
        go_v[0]  = 1'b0;
        bak_v[0] = 1'b1;
        tk; tk;
        rst_n = 1'b1;
        repeat (10) tk;
        chk("post rst busrq", 32'(busrq_v[0]), 0);
        chk("post rst busy", 32'(busy_v[0]), 0);

        repeat (4) tk;
        chk("writes drained", wq.size(), 0);
        chk("events drained", eq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
